// File: rtl/imem_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch unit and its buffer FIFO.
package imem_fetch_pkg;

    localparam int unsigned ADDR_SIZE        = 31;
    localparam int unsigned INSTR_SIZE       = 31;
    localparam int unsigned FETCH_FIFO_DEPTH = 4;
    localparam int unsigned RESET_PC_DEF     = 0;
    localparam int unsigned PC_INC_DEF       = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_BUSY    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imem_fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
module imem_fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_FIFO_DEPTH,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/imem_fetch.sv
// Instruction-fetch initiator: one outstanding imem read, redirect/discard handling,
// and a small FIFO of {pc, instruction} feeding decode.
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter int unsigned         ADDR_W   = ADDR_SIZE + 1,
    parameter int unsigned         INSTR_W  = INSTR_SIZE + 1,
    parameter int unsigned         DEPTH    = FETCH_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0]   PC_INC   = ADDR_W'(PC_INC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_rd_addr,
    output logic               imem_rd_enable,
    input  logic [INSTR_W-1:0] imem_rd_data,
    input  logic               imem_rd_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_en_q, rd_en_d;

    logic                push, pop, flush;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ADDR_W+INSTR_W-1:0] fifo_rdata;
    logic [CNT_W:0]      occ_after_push;
    logic                space_idle, space_after_push;

    assign instr_valid = !fifo_empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;

    // Occupancy after this cycle's pop (and, in the BUSY/ready case, push).
    assign space_idle       = !fifo_full || pop;
    assign occ_after_push   = {1'b0, fifo_count} - (CNT_W+1)'(pop) + (CNT_W+1)'(1);
    assign space_after_push = occ_after_push < (CNT_W+1)'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = rd_en_q;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    flush      = 1'b1;
                end else if (space_idle) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = fetch_pc_q;
                    state_d   = FETCH_BUSY;
                end
            end
            FETCH_BUSY: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc;
                    if (imem_rd_ready) begin
                        rd_addr_d = redirect_pc;
                        rd_en_d   = 1'b1;
                    end else begin
                        state_d = FETCH_DISCARD;
                    end
                end else if (imem_rd_ready) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INC;
                    if (space_after_push) begin
                        rd_addr_d = fetch_pc_q + PC_INC;
                    end else begin
                        rd_en_d = 1'b0;
                        state_d = FETCH_IDLE;
                    end
                end
            end
            FETCH_DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    flush      = 1'b1;
                end
                // Stale response is dropped; the latest target wins, even if redirected this cycle.
                if (imem_rd_ready) begin
                    rd_addr_d = redirect_valid ? redirect_pc : fetch_pc_q;
                    state_d   = FETCH_BUSY;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            rd_addr_q  <= RESET_PC;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
        end
    end

    imem_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({fetch_pc_q, imem_rd_data}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign imem_rd_addr   = rd_addr_q;
    assign imem_rd_enable = rd_en_q;
    assign instr_pc       = fifo_rdata[ADDR_W+INSTR_W-1:INSTR_W];
    assign instr_data     = fifo_rdata[INSTR_W-1:0];

endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
- Instruction-fetch initiator that drives the instruction-memory read interface (addr/enable out, data/ready in) on behalf of the core pipeline.
- Sequences the PC, issues one outstanding read at a time, and buffers returned instructions with their PCs in a small FIFO for decode.
- Supports redirect (branch/jump/trap) with flush and discard of any in-flight response.
- Sits between the imem responder and decode inside minuteCore.

Parameters:
- ADDR_W, `ADDR_SIZE+1, imem address / PC width
- INSTR_W, `INSTR_SIZE+1, instruction width
- DEPTH, 4, instruction FIFO entries (power of 2, ≥2)
- RESET_PC, 0, first fetch address after reset
- PC_INC, 4, PC increment per fetched instruction

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_rd_addr  out  ADDR_W  read address, registered
- imem_rd_enable  out  1  read request, registered
- imem_rd_data  in  INSTR_W  read data, valid when imem_rd_ready=1
- imem_rd_ready  in  1  response strobe, one cycle per request
- instr_valid  out  1  FIFO head valid to decode
- instr_data  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  head PC
- instr_ready  in  1  decode consumes head when instr_valid&instr_ready
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new fetch PC

Behaviour:
- Protocol:
  - Once enable is raised, addr and enable are held stable until ready is sampled high.
  - Responder latency is ≥1 cycle and variable.
  - At most one outstanding request.
  - ready sampled while in IDLE is ignored.
- Reset (async): state=IDLE, imem_rd_enable=0, imem_rd_addr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, instr_valid=0.
- space: true when the FIFO count after this cycle's push/pop is < DEPTH.
- IDLE:
  - If redirect_valid: fetch_pc←redirect_pc, FIFO flushed.
  - Else if space: enable←1, addr←fetch_pc, go BUSY.
  - First request: enable rises on the first clk edge after reset deasserts.
- BUSY, ready=0, no redirect: hold.
- BUSY, ready=1, no redirect:
  - Push {fetch_pc, data}; fetch_pc+=PC_INC, wrapping modulo 2^ADDR_W.
  - If space after the push: addr←new fetch_pc, enable stays 1 (back-to-back), remain BUSY.
  - Else: enable←0, go IDLE.
- BUSY, redirect, ready=0: flush FIFO, fetch_pc←redirect_pc, go DISCARD. Addr and enable are held.
- BUSY, redirect, ready=1: response dropped (not pushed), flush FIFO, addr←redirect_pc, enable=1, remain BUSY.
- DISCARD:
  - Enable and old addr are held until ready.
  - On ready: data dropped, addr←fetch_pc, go BUSY.
  - Redirect in DISCARD: fetch_pc←redirect_pc, stay DISCARD.
  - Redirect coincident with ready: the new redirect_pc is used for the next request.
- FIFO:
  - Push and pop in the same cycle are allowed, including at full.
  - Pop on empty and push on full never occur by construction; assert in simulation.
  - Flush empties the FIFO on the clock edge; a pop in the same cycle is void.
- Output gating: instr_valid = FIFO non-empty AND NOT redirect_valid (combinational gate). instr_data and instr_pc show the FIFO head and are don't-care when instr_valid=0.
- Throughput: one instruction per cycle when the responder answers with 1-cycle latency and decode never stalls.

Decomposition:
- def_params.v additions:
  - `FETCH_IDLE/`FETCH_BUSY/`FETCH_DISCARD 2-bit state encodings
  - `FETCH_FIFO_DEPTH default
  - `RESET_PC
  - `PC_INC
- Sub-module fetch_fifo:
  - Sync FIFO (DEPTH x (ADDR_W+INSTR_W)) with push, pop, flush, count, full, empty.
  - Async active-high reset.
  - Pointer wrap via DEPTH power-of-2.

Test Plan:
- Reset release, 1-cycle imem, instr_ready=1 -> enable=1 with addr=0 at first edge; instr_pc sequence 0,4,8,12 on consecutive cycles; data matches imem contents.
- instr_ready=0, DEPTH=4 -> exactly 4 pushes (PC 0..12); enable drops after the 4th ready; no further request until a pop, then addr=16.
- 3-cycle imem latency -> addr held stable for all 3 cycles per request; one outstanding request; PCs 0,4,8 delivered in order.
- Redirect to 0x100 while request for 8 is pending -> FIFO empties; instr_valid=0 that cycle; response for 8 discarded; next addr=0x100; first delivered instr_pc=0x100.
- Redirect to 0x40 coincident with ready -> response not delivered; addr=0x40 same following cycle; second redirect to 0x80 during DISCARD -> next request is 0x80.
- Assert reset mid-BUSY with FIFO holding 2 entries -> outputs immediately return to reset values (enable=0, instr_valid=0); fetch restarts at RESET_PC.
